// File: rtl/alu_pkg.sv
// Shared types for the operand-bank front end: button conditioner state and
// the default debounce length.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs (button and switches).
// The stage-1 flop is used only by the stage-2 flop.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/btn_load_conditioner.sv
// Turns the raw push-button into a debounced level and a single-cycle load
// strobe per accepted press, plus a wrapping press counter for debug LEDs.
module btn_load_conditioner
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       load_pulse,
  output logic       btn_level,
  output logic       busy,
  output logic [7:0] press_cnt,
  output btn_state_t dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_param_check
    $error("btn_load_conditioner: DEBOUNCE_CYCLES out of range for CNT_W");
  end

  logic             btn_s2;
  btn_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load_pulse_q;
  logic             btn_level_q;
  logic [7:0]       press_cnt_q;

  sync_2ff #(.W(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_raw),
    .q_o (btn_s2)
  );

  assign cnt_d = cnt_q + CNT_ONE;

  // Counter only runs in the ARM states and is cleared on every exit from them,
  // so it tops out at DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      load_pulse_q <= 1'b0;
      btn_level_q  <= 1'b0;
      press_cnt_q  <= 8'd0;
    end else begin
      load_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s2) begin
            state_q <= ARM_PRESS;
            cnt_q   <= CNT_ONE;
          end
        end
        ARM_PRESS: begin
          if (!btn_s2) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= HELD;
            cnt_q        <= '0;
            btn_level_q  <= 1'b1;
            load_pulse_q <= 1'b1;
            press_cnt_q  <= press_cnt_q + 8'd1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HELD: begin
          if (!btn_s2) begin
            state_q <= ARM_RELEASE;
            cnt_q   <= CNT_ONE;
          end
        end
        ARM_RELEASE: begin
          if (btn_s2) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            btn_level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign load_pulse = load_pulse_q;
  assign btn_level  = btn_level_q;
  assign press_cnt  = press_cnt_q;
  assign busy       = (state_q == ARM_PRESS) || (state_q == ARM_RELEASE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_btn_load_conditioner.sv
// Bench for btn_load_conditioner with a short debounce window: run-length
// reference model checked every cycle, plus directed latency/count checks.
module tb_btn_load_conditioner;
  import alu_pkg::*;

  localparam int DEB = 4;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       load_pulse;
  logic       btn_level;
  logic       busy;
  logic [7:0] press_cnt;
  btn_state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  btn_load_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .load_pulse (load_pulse),
    .btn_level  (btn_level),
    .busy       (busy),
    .press_cnt  (press_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the synchronised input is the raw value two edges old;
  // the level flips once the synchronised input has disagreed with it for DEB
  // consecutive edges, and a press (0->1 flip) produces one pulse.
  logic       m_s1, m_s2, m_level, m_pulse;
  int         m_run;
  logic [7:0] m_press;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_level <= 1'b0; m_pulse <= 1'b0;
      m_run <= 0; m_press <= 8'd0;
    end else begin
      m_s1    <= btn_raw;
      m_s2    <= m_s1;
      m_pulse <= 1'b0;
      if (m_s2 != m_level) begin
        if (m_run + 1 == DEB) begin
          m_level <= m_s2;
          m_run   <= 0;
          if (m_s2) begin
            m_pulse <= 1'b1;
            m_press <= m_press + 8'd1;
          end
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every cycle, away from the active edge
  int pulse_total = 0;
  int busy_total  = 0;
  int low_total   = 0;
  always @(negedge clk) begin
    chk("load_pulse", 32'(load_pulse), 32'(m_pulse));
    chk("btn_level",  32'(btn_level),  32'(m_level));
    chk("busy",       32'(busy),       32'(m_run != 0));
    chk("press_cnt",  32'(press_cnt),  32'(m_press));
    if (load_pulse) pulse_total++;
    if (busy) busy_total++;
    if (!btn_level) low_total++;
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic drive_raw(input logic v);
    @(negedge clk); #2;
    btn_raw = v;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask

  // Count posedges (starting with the next one) until sig_sel goes to want.
  task automatic edges_until(input int sel, input logic want, output int edges);
    logic seen;
    seen  = 1'b0;
    edges = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if ((sel == 0 ? load_pulse : btn_level) == want) seen = 1'b1;
    end
    if (!seen) edges = -1;
  endtask

  int e, p0, b0, l0;

  initial begin
    rst = 1'b0;
    btn_raw = 1'b1;

    // 1: reset with the button held, then qualification after release
    repeat (3) @(posedge clk);
    #1;
    chk("t1_rst_pulse", 32'(load_pulse), 0);
    chk("t1_rst_level", 32'(btn_level), 0);
    chk("t1_rst_busy",  32'(busy), 0);
    chk("t1_rst_press", 32'(press_cnt), 0);
    @(negedge clk); #2;
    rst = 1'b1;
    p0 = pulse_total;
    edges_until(0, 1'b1, e);
    chk("t1_latency", 32'(e), 6);
    cyc(10);
    chk("t1_level", 32'(btn_level), 1);
    chk("t1_press", 32'(press_cnt), 1);
    chk("t1_pulses", 32'(pulse_total - p0), 1);

    // 2: bounce shorter than the window
    btn_raw = 1'b0;
    do_reset();
    cyc(3);
    p0 = pulse_total; b0 = busy_total;
    drive_raw(1); drive_raw(0); drive_raw(1); drive_raw(0);
    cyc(12);
    chk("t2_pulses", 32'(pulse_total - p0), 0);
    chk("t2_level", 32'(btn_level), 0);
    chk("t2_press", 32'(press_cnt), 0);
    chk("t2_busy_seen", 32'(busy_total - b0 > 0), 1);

    // 3: clean press, long hold, release
    p0 = pulse_total;
    drive_raw(1);
    cyc(50);
    chk("t3_level_held", 32'(btn_level), 1);
    chk("t3_state_held", 32'(dbg_state), 32'(HELD));
    drive_raw(0);
    edges_until(1, 1'b0, e);
    chk("t3_release_latency", 32'(e), 6);
    cyc(10);
    chk("t3_pulses", 32'(pulse_total - p0), 1);
    chk("t3_press", 32'(press_cnt), 1);

    // 4: release glitch while held
    drive_raw(1);
    cyc(12);
    p0 = pulse_total; l0 = low_total;
    drive_raw(0);
    drive_raw(0);
    drive_raw(1);
    cyc(12);
    chk("t4_level_low_cycles", 32'(low_total - l0), 0);
    chk("t4_pulses", 32'(pulse_total - p0), 0);
    chk("t4_state", 32'(dbg_state), 32'(HELD));
    chk("t4_press", 32'(press_cnt), 2);
    drive_raw(0);
    cyc(12);

    // 5: 257 presses wrap the counter
    do_reset();
    cyc(2);
    p0 = pulse_total;
    for (int i = 0; i < 257; i++) begin
      drive_raw(1);
      cyc(8);
      drive_raw(0);
      cyc(8);
    end
    cyc(4);
    chk("t5_pulses", 32'(pulse_total - p0), 257);
    chk("t5_press_wrap", 32'(press_cnt), 1);

    // 6: asynchronous reset mid-qualification
    do_reset();
    cyc(3);
    drive_raw(1);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_state_arm", 32'(dbg_state), 32'(ARM_PRESS));
    chk("t6_busy_arm", 32'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_busy", 32'(busy), 0);
    chk("t6_async_state", 32'(dbg_state), 32'(IDLE));
    chk("t6_async_press", 32'(press_cnt), 0);
    chk("t6_async_pulse", 32'(load_pulse), 0);
    cyc(2);
    p0 = pulse_total;
    @(negedge clk); #2;
    rst = 1'b1;
    edges_until(0, 1'b1, e);
    chk("t6_latency", 32'(e), 6);
    cyc(15);
    chk("t6_pulses", 32'(pulse_total - p0), 1);
    chk("t6_press", 32'(press_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_load_conditioner.md
Name: btn_load_conditioner

Overview:
- Upstream stage of the A/B operand register bank: turns the raw, bouncing, asynchronous push-button into a clean single-cycle load strobe that drives the register bank's `btn_load` input.
- Synchronises the button, debounces it with a cycle counter, and emits exactly one `load_pulse` per physical press.
- Also provides the debounced level and a wrapping press counter for on-board debug LEDs.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive synchronised cycles the input must hold a new level before it is accepted (10 ms at 100 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20, width of the debounce counter; elaboration error if 2^CNT_W-1 < DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- btn_raw  input  1  raw push-button, asynchronous, bouncing.
- load_pulse  output  1  one-cycle strobe per accepted press; connects to the register bank's `btn_load`.
- btn_level  output  1  debounced button level.
- busy  output  1  high while a level change is being qualified (counter running).
- press_cnt  output  8  accepted presses, modulo 256.

Behaviour:
- Reset (rst=0, asynchronous):
  - sync flops = 0, counter = 0, state = IDLE.
  - load_pulse = 0, btn_level = 0, busy = 0, press_cnt = 0.
  - Release is synchronous to clk.
- Synchroniser: two-flop chain btn_raw -> s1 -> s2. Only s2 is used downstream. s1/s2 have no other fanout.
- FSM states:
  - IDLE: level 0, counter 0.
  - ARM_PRESS: s2=1 being qualified.
  - HELD: level 1, counter 0.
  - ARM_RELEASE: s2=0 being qualified.
- Transitions:
  - IDLE: s2=1 -> ARM_PRESS with cnt<=1; else stay.
  - ARM_PRESS:
    - s2=0 -> IDLE, cnt<=0 (bounce rejected, no pulse).
    - s2=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt<=0, btn_level<=1, load_pulse<=1, press_cnt<=press_cnt+1.
    - otherwise cnt<=cnt+1.
  - HELD: s2=0 -> ARM_RELEASE with cnt<=1; else stay.
  - ARM_RELEASE:
    - s2=1 -> HELD, cnt<=0.
    - s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt<=0, btn_level<=0. No pulse on release.
    - otherwise cnt<=cnt+1.
- Latency:
  - If btn_raw rises steadily before clock edge k, s2=1 after edge k+1.
  - btn_level and load_pulse go high after edge k+1+DEBOUNCE_CYCLES.
  - Release is symmetric for btn_level.
- Output timing:
  - load_pulse is registered and high for exactly one cycle; it is 0 in every cycle that is not the ARM_PRESS->HELD transition.
  - busy = (state==ARM_PRESS || state==ARM_RELEASE), combinational from state.
- Boundary conditions:
  - Button held indefinitely: one pulse only; no auto-repeat.
  - Glitch shorter than DEBOUNCE_CYCLES synchronised cycles: no pulse, no btn_level change, press_cnt unchanged.
  - press_cnt wraps 255 -> 0 on the 256th press.
  - Reset asserted mid-qualification or while HELD: all state cleared immediately, no pulse.
  - After reset release with the button still held: the press is qualified normally and produces one pulse.
  - Counter never exceeds DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package `alu_pkg`:
  - `btn_state_t` enum (IDLE, ARM_PRESS, HELD, ARM_RELEASE), 2-bit.
  - `localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000`.
- Sub-module `sync_2ff` for the synchroniser, reused for the switch inputs. Debounce FSM and counter stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
1. rst=0 for 3 cycles with btn_raw=1 -> all outputs 0. After release, hold btn_raw=1: load_pulse high exactly one cycle, 6 edges after the first sampled 1 (2 sync + 4); btn_level=1; press_cnt=1.
2. Bounce: btn_raw toggles 1,0,1,0 each cycle, then stays 0 -> load_pulse never asserts, btn_level stays 0, busy pulses; press_cnt=0.
3. Clean press, hold 50 cycles, release for 10 cycles -> exactly one load_pulse. btn_level falls 6 edges after btn_raw falls. No pulse on release.
4. Release glitch: while HELD, btn_raw=0 for 2 cycles, then 1 -> btn_level stays 1, no second pulse, state returns to HELD.
5. 257 clean press/release cycles -> press_cnt reads 1. load_pulse count = 257.
6. Assert rst=0 while in ARM_PRESS at cnt=2 -> outputs 0 immediately (asynchronously). After release with btn_raw still 1, exactly one pulse follows after 6 edges.
